// File: rtl/exec_unit.sv
// exec_unit: four-state (IDLE/READ/EXEC/WB) execution unit with register-file read/write ports.
// Define EXEC_UNIT_MUL_EN to build the iterative shift-add MUL (opcode 9); otherwise opcode 9 is illegal.
module exec_unit #(
   parameter int DATA_W = 16,
   parameter int AW     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [AW-1:0]     rd0_addr,
   output logic [AW-1:0]     rd1_addr,
   input  logic [DATA_W-1:0] rd0_data,
   input  logic [DATA_W-1:0] rd1_data,
   output logic              wr_en,
   output logic [AW-1:0]     wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              flag_z,
   output logic              flag_c,
   output logic              illegal
);
   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_ADDI = 4'd8;
`ifdef EXEC_UNIT_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam int         CW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`endif

   state_t              r_state;
   logic [15:0]         r_instr;
   logic [DATA_W-1:0]   r_op0;
   logic [DATA_W-1:0]   r_op1;
   logic [DATA_W-1:0]   r_res;
   logic                r_carry;
   logic                r_wr_en;
   logic [AW-1:0]       r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic                r_z;
   logic                r_c;
   logic                r_ill;
`ifdef EXEC_UNIT_MUL_EN
   logic [DATA_W-1:0]   r_acc;
   logic [CW-1:0]       r_cnt;
   logic [DATA_W-1:0]   w_acc_nxt;
`endif

   logic [3:0]          w_opc;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W:0]     w_diff;
   logic [DATA_W:0]     w_sumi;
   logic [DATA_W-1:0]   w_res;
   logic                w_c;

   function automatic logic op_legal(input logic [3:0] op);
`ifdef EXEC_UNIT_MUL_EN
      return op <= 4'd9;
`else
      return op <= 4'd8;
`endif
   endfunction

   assign w_opc  = r_instr[15:12];
   // carry/borrow fall out of bit DATA_W of the widened sums
   assign w_sum  = {1'b0, r_op0} + {1'b0, r_op1};
   assign w_diff = {1'b0, r_op0} - {1'b0, r_op1};
   assign w_sumi = {1'b0, r_op0} + (DATA_W+1)'(r_instr[5:0]);

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      case (w_opc)
         OP_ADD:  {w_c, w_res} = w_sum;
         OP_SUB:  {w_c, w_res} = w_diff;
         OP_AND:  w_res = r_op0 & r_op1;
         OP_OR:   w_res = r_op0 | r_op1;
         OP_XOR:  w_res = r_op0 ^ r_op1;
         OP_SHL:  w_res = r_op0 << r_op1[3:0];
         OP_SHR:  w_res = r_op0 >> r_op1[3:0];
         OP_ADDI: {w_c, w_res} = w_sumi;
         default: ;
      endcase
   end

`ifdef EXEC_UNIT_MUL_EN
   assign w_acc_nxt = r_acc + (r_op1[0] ? r_op0 : '0);
`endif

   assign instr_ready = (r_state == IDLE);
   assign rd0_addr    = AW'(r_instr[8:6]);
   assign rd1_addr    = AW'(r_instr[5:3]);
   assign wr_en       = r_wr_en;
   assign wr_addr     = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign flag_z      = r_z;
   assign flag_c      = r_c;
   assign illegal     = r_ill;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_instr   <= '0;
         r_op0     <= '0;
         r_op1     <= '0;
         r_res     <= '0;
         r_carry   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_z       <= 1'b0;
         r_c       <= 1'b0;
         r_ill     <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
         r_acc     <= '0;
         r_cnt     <= '0;
`endif
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (instr_valid) begin
                  r_instr <= instr;
                  r_state <= READ;
                  if (op_legal(instr[15:12])) r_ill <= 1'b0;
               end
            end
            READ: begin
               r_op0   <= rd0_data;
               r_op1   <= rd1_data;
               r_state <= EXEC;
`ifdef EXEC_UNIT_MUL_EN
               r_acc   <= '0;
               r_cnt   <= '0;
`endif
            end
            EXEC: begin
               if (!op_legal(w_opc)) begin
                  r_ill   <= 1'b1;
                  r_state <= IDLE;
               end else if (w_opc == OP_NOP) begin
                  r_state <= IDLE;
               end
`ifdef EXEC_UNIT_MUL_EN
               // one multiplier bit per cycle: op0 walks left, op1 walks right
               else if (w_opc == OP_MUL) begin
                  r_acc <= w_acc_nxt;
                  r_op0 <= r_op0 << 1;
                  r_op1 <= r_op1 >> 1;
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == CW'(DATA_W-1)) begin
                     r_res   <= w_acc_nxt;
                     r_carry <= 1'b0;
                     r_state <= WB;
                  end
               end
`endif
               else begin
                  r_res   <= w_res;
                  r_carry <= w_c;
                  r_state <= WB;
               end
            end
            WB: begin
               // first WB cycle launches the write and flags; second cycle drains it
               if (!r_wr_en) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= AW'(r_instr[11:9]);
                  r_wr_data <= r_res;
                  r_z       <= (r_res == '0);
                  r_c       <= r_carry;
               end else begin
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: random + directed stimulus against a cycle-scheduled instruction-level model of exec_unit.
module tb_exec_unit;
`ifdef EXEC_UNIT_MUL_EN
   localparam bit MULEN = 1'b1;
`else
   localparam bit MULEN = 1'b0;
`endif
   localparam int MUL_EXTRA = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready;
   logic [2:0]  rd0_addr, rd1_addr;
   logic [15:0] rd0_data, rd1_data;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        flag_z, flag_c, illegal;

   exec_unit #(.DATA_W(16), .AW(3)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd0_data(rd0_data), .rd1_data(rd1_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // environment register file
   logic [15:0] rf [8];
   logic        pl_en = 1'b0;
   logic [2:0]  pl_addr = '0;
   logic [15:0] pl_data = '0;
   assign rd0_data = rf[rd0_addr];
   assign rd1_data = rf[rd1_addr];
   always @(posedge clk) begin
      if (pl_en) rf[pl_addr] <= pl_data;
      else if (wr_en) rf[wr_addr] <= wr_data;
   end

   // literal expectations posted by the stimulus
   int          lit_seq = 0;
   bit          lit_wr;
   logic [15:0] lit_data;
   bit          lit_z, lit_c;
   int          lit_lat;

   // model state, owned by the compare process
   int          nvec = 0, nerr = 0, cyc = 0;
   logic [15:0] mrf [8];
   int          m_free = 0, m_wr_cyc = -1, m_ill_cyc = -1, m_clr_cyc = -1, m_src_cyc = -1;
   logic [2:0]  m_wr_addr, m_src0, m_src1, m_src0_n, m_src1_n;
   logic [15:0] m_wr_data;
   bit          m_z_n, m_c_n, m_z, m_c, m_ill;
   bit          acc_pend = 1'b0;
   int          lit_done = 0;
   bit          p_lit = 1'b0, p_lit_wr, p_lit_z, p_lit_c;
   logic [15:0] p_lit_data;
   int          p_lit_lat, p_n;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic accept();
      int unsigned a, b, t;
      logic [3:0]  op;
      logic [15:0] r;
      bit          c, legal;
      int          n;
      n  = cyc + 1;
      op = instr[15:12];
      a  = mrf[instr[8:6]];
      b  = mrf[instr[5:3]];
      legal = (op <= 4'd8) || (op == 4'd9 && MULEN);
      r = '0; c = 1'b0; t = 0;
      case (op)
         4'd1: begin t = a + b; c = t > 65535; end
         4'd2: begin t = a - b; c = a < b; end
         4'd3: t = a & b;
         4'd4: t = a | b;
         4'd5: t = a ^ b;
         4'd6: t = a << (b % 16);
         4'd7: t = a >> (b % 16);
         4'd8: begin t = a + instr[5:0]; c = t > 65535; end
         4'd9: t = a * b;
         default: ;
      endcase
      r = t[15:0];
      if (legal) m_clr_cyc = n;
      if (!legal) begin
         m_ill_cyc = n + 2;
         m_free    = n + 2;
      end else if (op == 4'd0) begin
         m_free = n + 2;
      end else begin
         m_wr_cyc  = n + 3 + ((op == 4'd9) ? MUL_EXTRA : 0);
         m_free    = m_wr_cyc + 1;
         m_wr_addr = instr[11:9];
         m_wr_data = r;
         m_z_n     = (r == 16'h0);
         m_c_n     = c;
      end
      m_src0_n  = instr[8:6];
      m_src1_n  = instr[5:3];
      m_src_cyc = n;
      acc_pend  = 1'b1;
      if (lit_seq != lit_done) begin
         lit_done   = lit_seq;
         p_lit      = 1'b1;
         p_lit_wr   = lit_wr;
         p_lit_data = lit_data;
         p_lit_z    = lit_z;
         p_lit_c    = lit_c;
         p_lit_lat  = lit_lat;
         p_n        = n;
         chk("lit_model_writes", {31'd0, legal && op != 4'd0}, {31'd0, lit_wr});
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      acc_pend = 1'b0;
      if (!rst) begin
         m_free = 0; m_wr_cyc = -1; m_ill_cyc = -1; m_clr_cyc = -1; m_src_cyc = -1;
         m_z = 0; m_c = 0; m_ill = 0; m_src0 = 0; m_src1 = 0; p_lit = 0;
         chk("rst_wr_en", wr_en, 0);
         chk("rst_wr_addr", wr_addr, 0);
         chk("rst_wr_data", wr_data, 0);
         chk("rst_flag_z", flag_z, 0);
         chk("rst_flag_c", flag_c, 0);
         chk("rst_illegal", illegal, 0);
         chk("rst_rd0_addr", rd0_addr, 0);
         chk("rst_rd1_addr", rd1_addr, 0);
      end else begin
         if (cyc == m_clr_cyc) m_ill = 1'b0;
         if (cyc == m_ill_cyc) m_ill = 1'b1;
         if (cyc == m_src_cyc) begin m_src0 = m_src0_n; m_src1 = m_src1_n; end
         if (cyc == m_wr_cyc) begin
            m_z = m_z_n; m_c = m_c_n; mrf[m_wr_addr] = m_wr_data;
         end
         if (pl_en) mrf[pl_addr] = pl_data;
         chk("instr_ready", instr_ready, cyc >= m_free);
         chk("wr_en", wr_en, cyc == m_wr_cyc);
         if (cyc == m_wr_cyc) begin
            chk("wr_addr", wr_addr, m_wr_addr);
            chk("wr_data", wr_data, m_wr_data);
         end
         chk("flag_z", flag_z, m_z);
         chk("flag_c", flag_c, m_c);
         chk("illegal", illegal, m_ill);
         chk("rd0_addr", rd0_addr, m_src0);
         chk("rd1_addr", rd1_addr, m_src1);
         if (p_lit && p_lit_wr && wr_en) begin
            chk("lit_latency", cyc - p_n, p_lit_lat);
            chk("lit_wr_data", wr_data, p_lit_data);
            chk("lit_flag_z", flag_z, p_lit_z);
            chk("lit_flag_c", flag_c, p_lit_c);
            p_lit = 1'b0;
         end else if (p_lit && !p_lit_wr && cyc == p_n + 2) begin
            chk("lit_illegal", illegal, 1);
            p_lit = 1'b0;
         end
         if (instr_valid && cyc >= m_free) accept();
      end
   end

   // all stimulus tasks start and end at posedge+1
   task automatic preload(input logic [2:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lit(input bit w, input logic [15:0] d, input bit z, input bit c, input int lat);
      lit_wr = w; lit_data = d; lit_z = z; lit_c = c; lit_lat = lat;
      lit_seq++;
   endtask

   task automatic send(input logic [15:0] ins, input bit keep);
      instr = ins;
      instr_valid = 1'b1;
      for (int t = 0; t < 60; t++) begin
         @(posedge clk);
         if (acc_pend) begin
            #1;
            if (!keep) instr_valid = 1'b0;
            return;
         end
      end
      $display("FAIL send_timeout: instruction %0h never accepted", ins);
      $fatal(1, "stimulus stalled");
   endtask

   function automatic logic [15:0] enc(input int op, input int d, input int s0, input int s1);
      return {4'(op), 3'(d), 3'(s0), 3'(s1), 3'b000};
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) preload(3'(i), 16'(i * 3 + 1));

      preload(1, 5); preload(2, 7);
      lit(1, 16'd12, 0, 0, 3); send(enc(1, 3, 1, 2), 0); idle(6);
      preload(1, 3); preload(2, 3);
      lit(1, 16'h0000, 1, 0, 3); send(enc(2, 3, 1, 2), 0); idle(6);
      preload(1, 2);
      lit(1, 16'hFFFF, 0, 1, 3); send(enc(2, 3, 1, 2), 0); idle(6);
      preload(1, 16'hFFFF); preload(2, 16'h0001);
      lit(1, 16'h0000, 1, 1, 3); send(enc(1, 4, 1, 2), 0); idle(6);
      preload(1, 16'h0010);
      lit(1, 16'h004F, 0, 0, 3); send({4'd8, 3'd3, 3'd1, 6'd63}, 0); idle(6);
      preload(1, 16'd300); preload(2, 16'd300);
      if (MULEN) lit(1, 16'h5F90, 0, 0, 3 + MUL_EXTRA);
      else       lit(0, 16'h0000, 0, 0, 0);
      send(enc(9, 6, 1, 2), 0); idle(24);

      // back-to-back: second instruction consumes the first one's result
      preload(1, 5); preload(2, 7);
      lit(1, 16'd12, 0, 0, 3); send(enc(1, 4, 1, 2), 1);
      lit(1, 16'd24, 0, 0, 3); send(enc(1, 5, 4, 4), 0); idle(8);

      // reset during EXEC of a MUL after leaving flags/illegal non-zero
      preload(1, 16'hFFFF); preload(2, 16'hFFFF);
      lit(1, 16'hFFFE, 0, 1, 3); send(enc(1, 7, 1, 2), 0); idle(6);
      send(enc(12, 0, 0, 0), 0); idle(4);
      send(enc(9, 6, 1, 2), 0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      preload(1, 16'd100); preload(2, 16'd23);
      lit(1, 16'd123, 0, 0, 3); send(enc(1, 3, 1, 2), 0); idle(6);

      // randomized phase
      for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
      for (int i = 0; i < 250; i++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         if ($urandom_range(0, 3) != 0) ins[15:12] = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 7) == 0) ins[5:3] = ins[8:6];
         send(ins, 1'($urandom_range(0, 1)));
         if (!instr_valid) idle($urandom_range(0, 2));
      end
      instr_valid = 1'b0;
      idle(30);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
